// File: rtl/mips_pkg.sv
// Shared register-file writeback types and constants.
// Queue entries carry their own valid bit so squashed slots can be dropped.
package mips_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [RF_ADDR_W-1:0] REG_RA   = 5'd31;

   typedef struct packed {
      logic                 valid;
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_pend_queue.sv
// Pending long-latency writeback FIFO with squash-by-address.
// Entries are compacted toward slot 0 each cycle, so the head is always slot 0.
module wb_pend_queue
   import mips_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  wb_entry_t               push_ent_i,
   input  logic                    pop_i,
   input  logic                    sq_i,
   input  logic [RF_ADDR_W-1:0]    sq_addr_i,
   input  logic [RF_ADDR_W-1:0]    qa_addr_i,
   input  logic [RF_ADDR_W-1:0]    qb_addr_i,
   output wb_entry_t               head_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [$clog2(DEPTH):0]  count_nxt_o,
   output logic [DEPTH-1:0]        match_a_o,
   output logic [DEPTH-1:0]        match_b_o
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW:0] ONE = 1;

   wb_entry_t   ent_q [DEPTH];
   wb_entry_t   ent_d [DEPTH];
   logic [IW:0] cnt_q;
   logic [IW:0] n;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_q[i].valid &&
             !((i == 0) && pop_i) &&
             !(sq_i && (ent_q[i].addr == sq_addr_i))) begin
            ent_d[n[IW-1:0]] = ent_q[i];
            n = n + ONE;
         end
      end
      if (push_i) ent_d[n[IW-1:0]] = push_ent_i;
   end

   assign count_nxt_o = push_i ? n + ONE : n;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         cnt_q <= count_nxt_o;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         match_a_o[i] = ent_q[i].valid && (ent_q[i].addr == qa_addr_i);
         match_b_o[i] = ent_q[i].valid && (ent_q[i].addr == qb_addr_i);
      end
   end

   assign head_o  = ent_q[0];
   assign count_o = cnt_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write port owner: pipeline WB has priority, long-latency
// writes wait in a small queue, with starvation relief and hazard lookup.
module regfile_wr_arbiter
   import mips_pkg::*;
#(
   parameter int ADDR_W     = RF_ADDR_W,
   parameter int DATA_W     = RF_DATA_W,
   parameter int Q_DEPTH    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p_valid_i,
   input  logic [ADDR_W-1:0] p_rt_i,
   input  logic [ADDR_W-1:0] p_rd_i,
   input  logic              p_reg_dest_i,
   input  logic              p_link_i,
   input  logic [DATA_W-1:0] p_data_i,
   output logic              p_stall_o,
   input  logic              m_valid_i,
   output logic              m_ready_o,
   input  logic [ADDR_W-1:0] m_waddr_i,
   input  logic [DATA_W-1:0] m_data_i,
   input  logic [ADDR_W-1:0] q_raddr_a_i,
   input  logic [ADDR_W-1:0] q_raddr_b_i,
   output logic              q_hit_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_waddr_o,
   output logic [DATA_W-1:0] rf_wdata_o
);

   localparam int CW = $clog2(Q_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] QFULL = CW'(Q_DEPTH);
   localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
   localparam logic [SW-1:0] SONE  = 1;

   logic [ADDR_W-1:0]  p_addr;
   logic               wr_p, pop, push, sq;
   wb_entry_t          head, push_ent;
   logic [CW-1:0]      q_cnt, q_cnt_d;
   logic [Q_DEPTH-1:0] match_a, match_b;
   logic               hit_a, hit_b;

   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              p_stall_q, p_stall_d;

   assign p_addr = p_link_i     ? REG_RA :
                   p_reg_dest_i ? p_rd_i : p_rt_i;

   // No pop bypass: a full queue refuses even while its head drains.
   assign m_ready_o = !rst_i && (q_cnt != QFULL);
   assign push      = m_valid_i && m_ready_o && (m_waddr_i != REG_ZERO);
   assign pop       = !p_valid_i && head.valid;
   assign wr_p      = p_valid_i && (p_addr != REG_ZERO);
   assign sq        = wr_p;
   assign push_ent  = '{valid: 1'b1, addr: m_waddr_i, data: m_data_i};

   wb_pend_queue #(
      .DEPTH (Q_DEPTH)
   ) u_q (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_ent_i  (push_ent),
      .pop_i       (pop),
      .sq_i        (sq),
      .sq_addr_i   (p_addr),
      .qa_addr_i   (q_raddr_a_i),
      .qb_addr_i   (q_raddr_b_i),
      .head_o      (head),
      .count_o     (q_cnt),
      .count_nxt_o (q_cnt_d),
      .match_a_o   (match_a),
      .match_b_o   (match_b)
   );

   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      unique case (1'b1)
         wr_p: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = p_addr;
            rf_wdata_d = p_data_i;
         end
         pop: begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head.addr;
            rf_wdata_d = head.data;
         end
         default: ;
      endcase
      starve_d = starve_q;
      if (pop || (q_cnt_d == '0))
         starve_d = '0;
      else if (p_valid_i && head.valid && (starve_q != SMAX))
         starve_d = starve_q + SONE;
      p_stall_d = (starve_d == SMAX) && !p_stall_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         starve_q   <= '0;
         p_stall_q  <= 1'b0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         starve_q   <= starve_d;
         p_stall_q  <= p_stall_d;
      end
   end

   assign hit_a = (q_raddr_a_i != REG_ZERO) &&
                  ((|match_a) || (rf_we_q && (rf_waddr_q == q_raddr_a_i)));
   assign hit_b = (q_raddr_b_i != REG_ZERO) &&
                  ((|match_b) || (rf_we_q && (rf_waddr_q == q_raddr_b_i)));

   assign q_hit_o    = hit_a || hit_b;
   assign p_stall_o  = p_stall_q;
   assign rf_we_o    = rf_we_q;
   assign rf_waddr_o = rf_waddr_q;
   assign rf_wdata_o = rf_wdata_q;

   ap_no_valid_in_stall: assert property (
      @(posedge clk_i) disable iff (rst_i) !(p_stall_q && p_valid_i));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_regfile_wr_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        p_valid, p_reg_dest, p_link, m_valid;
   logic [4:0]  p_rt, p_rd, m_waddr, ra, rb;
   logic [31:0] p_data, m_data;
   logic        p_stall, m_ready, q_hit, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wr_arbiter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .p_valid_i    (p_valid),
      .p_rt_i       (p_rt),
      .p_rd_i       (p_rd),
      .p_reg_dest_i (p_reg_dest),
      .p_link_i     (p_link),
      .p_data_i     (p_data),
      .p_stall_o    (p_stall),
      .m_valid_i    (m_valid),
      .m_ready_o    (m_ready),
      .m_waddr_i    (m_waddr),
      .m_data_i     (m_data),
      .q_raddr_a_i  (ra),
      .q_raddr_b_i  (rb),
      .q_hit_o      (q_hit),
      .rf_we_o      (rf_we),
      .rf_waddr_o   (rf_waddr),
      .rf_wdata_o   (rf_wdata)
   );

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          m_starve;
   bit          m_stall, m_we, known;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit mdl_hit(input logic [4:0] r);
      if (r == 0) return 1'b0;
      if (m_we && m_wa == r) return 1'b1;
      foreach (mq[i]) if (mq[i].a == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void mdl_step();
      logic [4:0] pa;
      int         sz0;
      bit         popped, rdy;
      ent_t       e;
      if (rst) begin
         mq.delete();
         m_starve = 0; m_stall = 0;
         m_we = 0; m_wa = 0; m_wd = 0;
         known = 1;
         return;
      end
      pa     = p_link ? 5'd31 : (p_reg_dest ? p_rd : p_rt);
      sz0    = mq.size();
      rdy    = sz0 < 2;
      popped = 0;
      m_we = 0; m_wa = 0; m_wd = 0;
      if (p_valid) begin
         if (pa != 0) begin
            m_we = 1; m_wa = pa; m_wd = p_data;
            for (int i = mq.size() - 1; i >= 0; i--)
               if (mq[i].a == pa) mq.delete(i);
         end
      end else if (sz0 > 0) begin
         e = mq.pop_front();
         popped = 1;
         m_we = 1; m_wa = e.a; m_wd = e.d;
      end
      if (m_valid && rdy && m_waddr != 0) mq.push_back('{m_waddr, m_data});
      if (popped || mq.size() == 0) m_starve = 0;
      else if (p_valid && sz0 > 0 && m_starve < SMAX) m_starve++;
      m_stall = (m_starve == SMAX) && !m_stall;
   endfunction

   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      #1;
      if (known) begin
         chk("m_rf_we", rf_we, m_we);
         chk("m_rf_waddr", rf_waddr, m_wa);
         chk("m_rf_wdata", rf_wdata, m_wd);
         chk("m_p_stall", p_stall, m_stall);
         chk("m_m_ready", m_ready, !rst && mq.size() < 2);
         chk("m_q_hit", q_hit, mdl_hit(ra) || mdl_hit(rb));
      end
      mdl_step();
      @(negedge clk);
   endtask

   task automatic idle_in();
      p_valid = 0; p_rt = 0; p_rd = 0; p_reg_dest = 0; p_link = 0; p_data = 0;
      m_valid = 0; m_waddr = 0; m_data = 0;
   endtask

   task automatic pipe(input logic [4:0] rt, input logic [31:0] d);
      p_valid = 1; p_rt = rt; p_rd = 0; p_reg_dest = 0; p_link = 0; p_data = d;
   endtask

   task automatic offer(input logic [4:0] a, input logic [31:0] d);
      m_valid = 1; m_waddr = a; m_data = d;
   endtask

   typedef struct {
      logic [4:0]  rt, rd;
      logic        rdst, lnk;
      logic [31:0] d;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{5'd8, 5'd9, 1'b1, 1'b0, 32'h1234, 1'b1, 5'd9,  32'h1234};
      vt[1] = '{5'd8, 5'd9, 1'b1, 1'b1, 32'h5678, 1'b1, 5'd31, 32'h5678};
      vt[2] = '{5'd0, 5'd9, 1'b0, 1'b0, 32'hDEAD, 1'b0, 5'd0,  32'h0};
      vt[3] = '{5'd8, 5'd9, 1'b0, 1'b0, 32'hBEEF, 1'b1, 5'd8,  32'hBEEF};
      vt[4] = '{5'd4, 5'd0, 1'b1, 1'b0, 32'h1,    1'b0, 5'd0,  32'h0};
      vt[5] = '{5'd0, 5'd0, 1'b0, 1'b1, 32'h77,   1'b1, 5'd31, 32'h77};

      known = 0;
      rst = 1; ra = 0; rb = 0;
      idle_in();
      cycle();
      cycle();
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_p_stall", p_stall, 0);
      chk("rst_m_ready", m_ready, 0);
      rst = 0;
      #1 chk("rel_m_ready", m_ready, 1);

      // dest select and $0 bubbles
      foreach (vt[i]) begin
         p_valid = 1; p_rt = vt[i].rt; p_rd = vt[i].rd;
         p_reg_dest = vt[i].rdst; p_link = vt[i].lnk; p_data = vt[i].d;
         cycle();
         chk($sformatf("vec%0d_we", i), rf_we, vt[i].we);
         chk($sformatf("vec%0d_waddr", i), rf_waddr, vt[i].wa);
         chk($sformatf("vec%0d_wdata", i), rf_wdata, vt[i].wd);
      end
      idle_in();
      cycle();

      // long-latency writes drain in order, 2 cycles after accept
      offer(5, 32'hAA);
      cycle();
      offer(6, 32'hBB);
      #1 chk("t2_ready1", m_ready, 1);
      cycle();
      chk("t2_we5", rf_we, 1);
      chk("t2_addr5", rf_waddr, 5);
      chk("t2_data5", rf_wdata, 32'hAA);
      idle_in();
      cycle();
      chk("t2_addr6", rf_waddr, 6);
      chk("t2_data6", rf_wdata, 32'hBB);
      cycle();
      chk("t2_idle_we", rf_we, 0);
      chk("t2_empty_ready", m_ready, 1);

      // starvation relief
      pipe(20, 32'h2000);
      offer(10, 32'hA0);
      cycle();
      offer(11, 32'hB0);
      cycle();
      offer(12, 32'hC0);
      #1 chk("t3_full_ready", m_ready, 0);
      chk("t3_stall0", p_stall, 0);
      cycle();
      chk("t3_stall1", p_stall, 0);
      cycle();
      chk("t3_stall2", p_stall, 0);
      cycle();
      chk("t3_stall_on", p_stall, 1);
      idle_in();
      cycle();
      chk("t3_head_we", rf_we, 1);
      chk("t3_head_addr", rf_waddr, 10);
      chk("t3_head_data", rf_wdata, 32'hA0);
      chk("t3_stall_off", p_stall, 0);
      chk("t3_ready_back", m_ready, 1);
      cycle();
      chk("t3_second_addr", rf_waddr, 11);
      cycle();

      // WAW squash
      pipe(3, 32'h33);
      offer(7, 32'h77);
      cycle();
      ra = 7;
      #1 chk("t4_hit_q", q_hit, 1);
      pipe(7, 32'h700);
      m_valid = 0;
      cycle();
      chk("t4_pipe_addr", rf_waddr, 7);
      chk("t4_pipe_data", rf_wdata, 32'h700);
      idle_in();
      cycle();
      chk("t4_no_stale_we", rf_we, 0);
      chk("t4_hit_fall", q_hit, 0);
      ra = 0;

      // hazard lookup, $0 offer dropped
      pipe(3, 32'h3);
      offer(5, 32'h55);
      cycle();
      ra = 5;
      #1 chk("t5_hit5", q_hit, 1);
      offer(0, 32'hF0);
      cycle();
      ra = 0;
      #1 chk("t5_hit0", q_hit, 0);
      chk("t5_ready_after_drop", m_ready, 1);
      idle_in();
      cycle();
      chk("t5_pop_addr", rf_waddr, 5);
      chk("t5_pop_data", rf_wdata, 32'h55);
      cycle();

      // reset with two pending entries
      pipe(3, 32'h3);
      offer(12, 32'hC);
      cycle();
      offer(13, 32'hD);
      cycle();
      rst = 1;
      idle_in();
      cycle();
      chk("t6_we", rf_we, 0);
      chk("t6_ready", m_ready, 0);
      chk("t6_stall", p_stall, 0);
      rst = 0;
      ra = 12;
      #1 chk("t6_ready_rel", m_ready, 1);
      chk("t6_hit_flushed", q_hit, 0);
      cycle();
      chk("t6_no_write", rf_we, 0);
      ra = 0;

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 149) == 0);
         p_valid    = p_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
         p_rt       = 5'($urandom_range(0, 7));
         p_rd       = 5'($urandom_range(0, 7));
         p_reg_dest = 1'($urandom_range(0, 1));
         p_link     = ($urandom_range(0, 7) == 0);
         p_data     = $urandom;
         m_valid    = 1'($urandom_range(0, 1));
         m_waddr    = 5'($urandom_range(0, 7));
         m_data     = $urandom;
         ra         = 5'($urandom_range(0, 7));
         rb         = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
